traffic_light_monitor: RTL and testbench
========================================

Name: traffic_light_monitor

Overview:
- Passive checker on the 12 lamp outputs of the 4-way traffic light controller; the receiving end of the lamp interface.
- Decodes which direction is active and in which phase.
- Tracks the rotation order and phase dwell times, and raises sticky fault flags on illegal lamp patterns, conflicts, out-of-order transitions or wrong durations.
- Sits beside the controller in the top level; its outputs feed status logic and the bench scoreboard.

Parameters:
- ORANGE_CYC, 5: exact required orange dwell, in clk cycles.
- GREEN_MIN, 25: minimum legal green dwell, in cycles.
- GREEN_MAX, 26: maximum legal green dwell, in cycles (the last direction's green runs one cycle longer).
- DWELL_W, 8: dwell counter width; the counter saturates at all-ones.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- red  in  4  Red lamps; bit i = direction i+1.
- orange  in  4  Orange lamps; bit i = direction i+1.
- green  in  4  Green lamps; bit i = direction i+1.
- clr  in  1  synchronous pulse; clears all sticky error flags.
- active_dir  out  2  index of the current non-red direction (0..3); 0 when idle.
- phase  out  2  0 = all-red/idle, 1 = orange, 2 = green, 3 = resync.
- err_lamp  out  1  sticky: some direction does not have exactly one lamp lit.
- err_conflict  out  1  sticky: more than one direction is non-red.
- err_seq  out  1  sticky: illegal transition.
- err_timing  out  1  sticky: phase left at an illegal dwell.
- fault  out  1  OR of the four error flags.
- rot_done  out  1  one-cycle pulse when direction 3 green hands over to direction 0 orange.
- rot_count  out  16  completed rotations; saturates at 0xFFFF.

Behaviour:
- Reset (rst low, asynchronous): all outputs 0, tracker in IDLE, dwell 0, sample register loaded with all-red.
- Pipeline: lamps are captured into a sample register each edge; decode, compare and flag updates happen at the next edge.
  - A pattern present before edge k is reflected on the outputs after edge k+1 (2-cycle latency).
- Per-sample decode:
  - Lamp code for direction d is valid iff exactly one of red/orange/green is set. Any invalid direction sets err_lamp.
  - Count the non-red directions. A count above 1 sets err_conflict.
  - Either condition makes the sample bad.
- Dwell counter: increments each cycle the decoded (dir, phase) is unchanged, saturating at 2^DWELL_W-1. It resets to 1 on a pattern change.
- Tracker FSM:
  - IDLE (all red):
    - all red: stay.
    - orange on direction 0: go to ORANGE(0).
    - any other non-red pattern: err_seq, go to RESYNC.
  - ORANGE(d):
    - unchanged: stay.
    - green on direction d: require dwell == ORANGE_CYC, otherwise err_timing; go to GREEN(d).
    - anything else: err_seq, go to RESYNC.
  - GREEN(d):
    - unchanged: stay.
    - orange on direction (d+1) mod 4: require GREEN_MIN ≤ dwell ≤ GREEN_MAX, otherwise err_timing; go to ORANGE(d+1).
      - If d == 3, also pulse rot_done and increment rot_count.
    - anything else, including falling back to all-red: err_seq, go to RESYNC.
  - RESYNC:
    - wait for a good sample with a single direction in orange, then go to ORANGE(that direction).
    - The first phase after resync is not timing-checked, but its exit dwell is checked.
    - No err_seq is raised while in RESYNC.
  - Bad sample in any state: tracker goes to RESYNC.
- Flags:
  - Sticky until clr.
  - If clr and a new error occur on the same cycle, the error wins (flag stays 1).
  - Several errors in one cycle all set.
- Saturation: a dwell count that saturates is still compared (it will fail the upper bound).
- active_dir and phase are registered from the tracker state. In RESYNC, active_dir holds its last value.

Decomposition:
- Shared package holds:
  - phase encoding constants (PH_IDLE, PH_ORANGE, PH_GREEN, PH_RESYNC);
  - direction count NUM_DIR = 4;
  - default ORANGE_CYC, GREEN_MIN and GREEN_MAX, also used by the controller and the bench.
- One natural sub-module: lamp_decode. It is combinational and takes red, orange and green. It outputs bad_lamp, conflict, any_nonred, dir index and phase, and is reused by the bench scoreboard.
- The tracker FSM, dwell counter and flags stay in the top module.

Test Plan:
- Reset, then drive the nominal controller sequence for 3 rotations (orange 5 cycles, green 25/25/25/26) → no errors, rot_done pulses 3 times, rot_count = 3, phase/active_dir follow with 2-cycle lag.
- Nominal run, but direction 1 (index 0) orange held 6 cycles → err_timing = 1, fault = 1, others 0. Then pulse clr → all flags 0 two cycles later.
- Drive orange[0] and orange[1] together for one cycle → err_conflict = 1, phase = 3 (resync). Next, orange[2] for 5 cycles then green[2] → resumes ORANGE(2)/GREEN(2) with no err_seq.
- Red and green both set on direction 2 → err_lamp = 1. Simultaneously pulse clr → err_lamp remains 1.
- From GREEN(1), jump to orange[3] (skipping direction 2) → err_seq = 1, tracker goes to RESYNC.
- Assert rst low mid-green for 1 cycle (asynchronous, between edges) → outputs 0 immediately, tracker IDLE. A subsequent orange on direction 1 (index 0) proceeds without error.

Source files
------------

// File: rtl/traffic_light_monitor_pkg.sv
// Shared constants for the traffic light lamp interface: phase codes,
// direction count and the controller's nominal dwell times.
package traffic_light_monitor_pkg;

  localparam int unsigned NUM_DIR = 4;

  localparam int unsigned DEF_ORANGE_CYC = 5;
  localparam int unsigned DEF_GREEN_MIN  = 25;
  localparam int unsigned DEF_GREEN_MAX  = 26;

  localparam logic [1:0] PH_IDLE   = 2'd0;
  localparam logic [1:0] PH_ORANGE = 2'd1;
  localparam logic [1:0] PH_GREEN  = 2'd2;
  localparam logic [1:0] PH_RESYNC = 2'd3;

  // Tracker state encodings line up with the PH_* phase codes.
  typedef enum logic [1:0] {
    TRK_IDLE   = 2'd0,
    TRK_ORANGE = 2'd1,
    TRK_GREEN  = 2'd2,
    TRK_RESYNC = 2'd3
  } trk_state_t;

endpackage

// File: rtl/traffic_light_monitor_lamp_decode.sv
// Combinational decode of one lamp sample: per-direction legality, conflict
// detection, and the active direction/phase of a well-formed sample.
module lamp_decode
  import traffic_light_monitor_pkg::*;
(
  input  logic [3:0] red,
  input  logic [3:0] orange,
  input  logic [3:0] green,
  output logic       bad_lamp,
  output logic       conflict,
  output logic       any_nonred,
  output logic [1:0] dir,
  output logic [1:0] phase
);

  logic [2:0] n_nonred;

  always_comb begin
    bad_lamp   = 1'b0;
    any_nonred = 1'b0;
    n_nonred   = '0;
    dir        = '0;
    for (int unsigned i = 0; i < NUM_DIR; i++) begin
      if (!((red[i] ^ orange[i] ^ green[i]) & ~(red[i] & orange[i] & green[i])))
        bad_lamp = 1'b1;
      if (orange[i] | green[i]) begin
        if (!any_nonred)
          dir = 2'(i);
        any_nonred = 1'b1;
        n_nonred   = n_nonred + 3'd1;
      end
    end
    conflict = (n_nonred > 3'd1);

    // A malformed sample never decodes as a legal phase.
    if (bad_lamp || conflict)
      phase = PH_RESYNC;
    else if (!any_nonred)
      phase = PH_IDLE;
    else if (orange[dir])
      phase = PH_ORANGE;
    else
      phase = PH_GREEN;
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive checker for the 4-way controller lamps: tracks rotation order and
// phase dwell times and raises sticky fault flags on any violation.
module traffic_light_monitor
  import traffic_light_monitor_pkg::*;
#(
  parameter int unsigned ORANGE_CYC = DEF_ORANGE_CYC,
  parameter int unsigned GREEN_MIN  = DEF_GREEN_MIN,
  parameter int unsigned GREEN_MAX  = DEF_GREEN_MAX,
  parameter int unsigned DWELL_W    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  red,
  input  logic [3:0]  orange,
  input  logic [3:0]  green,
  input  logic        clr,
  output logic [1:0]  active_dir,
  output logic [1:0]  phase,
  output logic        err_lamp,
  output logic        err_conflict,
  output logic        err_seq,
  output logic        err_timing,
  output logic        fault,
  output logic        rot_done,
  output logic [15:0] rot_count
);

  localparam logic [DWELL_W-1:0] ORANGE_DW    = DWELL_W'(ORANGE_CYC);
  localparam logic [DWELL_W-1:0] GREEN_MIN_DW = DWELL_W'(GREEN_MIN);
  localparam logic [DWELL_W-1:0] GREEN_MAX_DW = DWELL_W'(GREEN_MAX);

  logic [3:0]         s_red, s_orange, s_green;
  logic               d_bad_lamp, d_conflict, d_any, d_bad;
  logic [1:0]         d_dir, d_phase;

  trk_state_t         state, nxt_state;
  logic [1:0]         cur_dir, nxt_dir;
  logic [1:0]         prev_dir, prev_ph;
  logic [DWELL_W-1:0] dwell;
  logic               changed, seq_e, tim_e, rot_e;

  lamp_decode u_decode (
    .red        (s_red),
    .orange     (s_orange),
    .green      (s_green),
    .bad_lamp   (d_bad_lamp),
    .conflict   (d_conflict),
    .any_nonred (d_any),
    .dir        (d_dir),
    .phase      (d_phase)
  );

  assign d_bad   = d_bad_lamp | d_conflict;
  assign changed = (d_dir != prev_dir) || (d_phase != prev_ph);
  assign fault   = err_lamp | err_conflict | err_seq | err_timing;

  always_comb begin
    nxt_state = state;
    nxt_dir   = cur_dir;
    seq_e     = 1'b0;
    tim_e     = 1'b0;
    rot_e     = 1'b0;
    if (d_bad) begin
      nxt_state = TRK_RESYNC;
    end else begin
      case (state)
        TRK_IDLE: begin
          if (d_phase == PH_ORANGE && d_dir == 2'd0) begin
            nxt_state = TRK_ORANGE;
            nxt_dir   = 2'd0;
          end else if (d_any) begin
            seq_e     = 1'b1;
            nxt_state = TRK_RESYNC;
          end
        end
        TRK_ORANGE: begin
          if (d_phase == PH_ORANGE && d_dir == cur_dir) begin
            nxt_state = TRK_ORANGE;
          end else if (d_phase == PH_GREEN && d_dir == cur_dir) begin
            tim_e     = (dwell != ORANGE_DW);
            nxt_state = TRK_GREEN;
          end else begin
            seq_e     = 1'b1;
            nxt_state = TRK_RESYNC;
          end
        end
        TRK_GREEN: begin
          if (d_phase == PH_GREEN && d_dir == cur_dir) begin
            nxt_state = TRK_GREEN;
          end else if (d_phase == PH_ORANGE && d_dir == cur_dir + 2'd1) begin
            tim_e     = (dwell < GREEN_MIN_DW) || (dwell > GREEN_MAX_DW);
            rot_e     = (cur_dir == 2'd3);
            nxt_state = TRK_ORANGE;
            nxt_dir   = cur_dir + 2'd1;
          end else begin
            seq_e     = 1'b1;
            nxt_state = TRK_RESYNC;
          end
        end
        default: begin
          if (d_any && d_phase == PH_ORANGE) begin
            nxt_state = TRK_ORANGE;
            nxt_dir   = d_dir;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_red        <= '1;
      s_orange     <= '0;
      s_green      <= '0;
      state        <= TRK_IDLE;
      cur_dir      <= '0;
      prev_dir     <= '0;
      prev_ph      <= PH_IDLE;
      dwell        <= '0;
      active_dir   <= '0;
      phase        <= PH_IDLE;
      err_lamp     <= 1'b0;
      err_conflict <= 1'b0;
      err_seq      <= 1'b0;
      err_timing   <= 1'b0;
      rot_done     <= 1'b0;
      rot_count    <= '0;
    end else begin
      s_red    <= red;
      s_orange <= orange;
      s_green  <= green;

      prev_dir <= d_dir;
      prev_ph  <= d_phase;
      if (changed)
        dwell <= DWELL_W'(1);
      else if (dwell != '1)
        dwell <= dwell + DWELL_W'(1);

      state      <= nxt_state;
      cur_dir    <= nxt_dir;
      active_dir <= nxt_dir;
      phase      <= nxt_state;

      // A fresh error on the clearing cycle takes priority over clr.
      err_lamp     <= (err_lamp     & ~clr) | d_bad_lamp;
      err_conflict <= (err_conflict & ~clr) | d_conflict;
      err_seq      <= (err_seq      & ~clr) | seq_e;
      err_timing   <= (err_timing   & ~clr) | tim_e;

      rot_done <= rot_e;
      if (rot_e && rot_count != '1)
        rot_count <= rot_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed vector bench for traffic_light_monitor: a table of lamp patterns
// with hand-computed outputs, plus reset and latency sequences.
module tb_traffic_light_monitor;
  import traffic_light_monitor_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  red = 4'hF, orange = 4'h0, green = 4'h0;
  logic        clr = 1'b0;
  logic [1:0]  active_dir, phase;
  logic        err_lamp, err_conflict, err_seq, err_timing, fault, rot_done;
  logic [15:0] rot_count;

  always #5 clk = ~clk;

  traffic_light_monitor #(
    .ORANGE_CYC (DEF_ORANGE_CYC),
    .GREEN_MIN  (DEF_GREEN_MIN),
    .GREEN_MAX  (DEF_GREEN_MAX),
    .DWELL_W    (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .red          (red),
    .orange       (orange),
    .green        (green),
    .clr          (clr),
    .active_dir   (active_dir),
    .phase        (phase),
    .err_lamp     (err_lamp),
    .err_conflict (err_conflict),
    .err_seq      (err_seq),
    .err_timing   (err_timing),
    .fault        (fault),
    .rot_done     (rot_done),
    .rot_count    (rot_count)
  );

  localparam int K_RED  = 0;
  localparam int K_OR   = 1;
  localparam int K_GR   = 2;
  localparam int K_CONF = 3;
  localparam int K_LB   = 4;

  // err field is {lamp, conflict, seq, timing}; expectations hold after the row's last edge.
  typedef struct {
    logic [3:0]  r, o, g;
    logic        c;
    logic        chk;
    int          n;
    logic [1:0]  ph, dir;
    logic [3:0]  err;
    logic [15:0] rot;
    int          pulses;
  } vec_t;

  vec_t vq[$];
  int   total = 0, passed = 0;
  int   pulses = 0;
  int   split1, split2;

  always @(negedge clk)
    if (rot_done === 1'b1) pulses++;

  task automatic add(input int kind, input int d, input int n, input logic c,
                     input logic chk, input logic [1:0] ph, input logic [1:0] dir,
                     input logic [3:0] err, input logic [15:0] rot, input int pl);
    vec_t v;
    logic [3:0] b;
    b = 4'b0001 << d;
    v.r = 4'hF; v.o = 4'h0; v.g = 4'h0;
    case (kind)
      K_OR:    begin v.r = ~b; v.o = b; end
      K_GR:    begin v.r = ~b; v.g = b; end
      K_CONF:  begin v.r = 4'b1100; v.o = 4'b0011; end
      K_LB:    begin v.r = 4'hF; v.g = 4'b0100; end
      default: ;
    endcase
    v.c = c; v.chk = chk; v.n = n; v.ph = ph; v.dir = dir;
    v.err = err; v.rot = rot; v.pulses = pl;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s row %0d: got %0h, expected %0h", name, row, act, exp);
    else
      passed++;
  endtask

  task automatic check_all(input int row, input logic [1:0] ph, input logic [1:0] dir,
                           input logic [3:0] err, input logic [15:0] rot, input int pl);
    check("phase", row, 32'(phase), 32'(ph));
    check("active_dir", row, 32'(active_dir), 32'(dir));
    check("err_flags", row, 32'({err_lamp, err_conflict, err_seq, err_timing}), 32'(err));
    check("fault", row, 32'(fault), 32'(|err));
    check("rot_count", row, 32'(rot_count), 32'(rot));
    check("rot_done", row, 32'(rot_done), 32'd0);
    check("rot_pulses", row, 32'(pulses), 32'(pl));
  endtask

  task automatic run_row(input int i);
    red = vq[i].r; orange = vq[i].o; green = vq[i].g; clr = vq[i].c;
    repeat (vq[i].n) @(posedge clk);
    #1;
    clr = 1'b0;
    if (vq[i].chk)
      check_all(i, vq[i].ph, vq[i].dir, vq[i].err, vq[i].rot, vq[i].pulses);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Three nominal rotations.
    add(K_RED, 0, 3, 0, 1, PH_IDLE, 2'd0, 4'b0000, 16'd0, 0);
    for (int r = 0; r < 3; r++)
      for (int d = 0; d < 4; d++) begin
        add(K_OR, d, 5, 0, 1, PH_ORANGE, 2'(d), 4'b0000, 16'(r), r);
        add(K_GR, d, (d == 3) ? 26 : 25, 0, 1, PH_GREEN, 2'(d), 4'b0000, 16'(r), r);
      end
    // Orange held 6 cycles, then clr mid-green.
    add(K_OR, 0, 6, 0, 1, PH_ORANGE, 2'd0, 4'b0000, 16'd3, 3);
    add(K_GR, 0, 23, 0, 1, PH_GREEN, 2'd0, 4'b0001, 16'd3, 3);
    add(K_GR, 0, 1, 1, 0, PH_GREEN, 2'd0, 4'b0000, 16'd3, 3);
    add(K_GR, 0, 1, 0, 1, PH_GREEN, 2'd0, 4'b0000, 16'd3, 3);
    add(K_OR, 1, 5, 0, 1, PH_ORANGE, 2'd1, 4'b0000, 16'd3, 3);
    add(K_GR, 1, 25, 0, 1, PH_GREEN, 2'd1, 4'b0000, 16'd3, 3);
    // Skip direction 2: one cycle of RESYNC, then orange 3 is adopted.
    add(K_OR, 3, 2, 0, 1, PH_RESYNC, 2'd1, 4'b0010, 16'd3, 3);
    add(K_OR, 3, 3, 0, 1, PH_ORANGE, 2'd3, 4'b0010, 16'd3, 3);
    add(K_GR, 3, 26, 0, 1, PH_GREEN, 2'd3, 4'b0010, 16'd3, 3);
    add(K_OR, 0, 4, 0, 1, PH_ORANGE, 2'd0, 4'b0010, 16'd4, 4);
    add(K_OR, 0, 1, 1, 0, PH_ORANGE, 2'd0, 4'b0000, 16'd4, 4);
    // Conflict, then resume on direction 2 with no sequence error.
    add(K_CONF, 0, 2, 0, 1, PH_RESYNC, 2'd0, 4'b0100, 16'd4, 4);
    add(K_OR, 2, 5, 0, 1, PH_ORANGE, 2'd2, 4'b0100, 16'd4, 4);
    add(K_GR, 2, 25, 0, 1, PH_GREEN, 2'd2, 4'b0100, 16'd4, 4);
    // Bad lamp code on direction 2 evaluated on the same edge as clr.
    add(K_LB, 0, 1, 0, 0, PH_GREEN, 2'd2, 4'b0100, 16'd4, 4);
    add(K_RED, 0, 1, 1, 1, PH_RESYNC, 2'd2, 4'b1000, 16'd4, 4);
    add(K_RED, 0, 3, 0, 1, PH_RESYNC, 2'd2, 4'b1000, 16'd4, 4);
    add(K_OR, 3, 5, 0, 1, PH_ORANGE, 2'd3, 4'b1000, 16'd4, 4);
    add(K_GR, 3, 10, 0, 1, PH_GREEN, 2'd3, 4'b1000, 16'd4, 4);
    split1 = vq.size();
    add(K_RED, 0, 3, 0, 1, PH_IDLE, 2'd0, 4'b0000, 16'd0, 4);
    split2 = vq.size();
    add(K_OR, 0, 3, 0, 1, PH_ORANGE, 2'd0, 4'b0000, 16'd0, 4);
    add(K_GR, 0, 25, 0, 1, PH_GREEN, 2'd0, 4'b0000, 16'd0, 4);
    add(K_OR, 1, 5, 0, 1, PH_ORANGE, 2'd1, 4'b0000, 16'd0, 4);

    #1;
    check_all(-1, PH_IDLE, 2'd0, 4'b0000, 16'd0, 0);
    #11 rst = 1'b1;

    for (int i = 0; i < split1; i++) run_row(i);

    // Asynchronous reset between edges, mid-green.
    #2;
    rst = 1'b0;
    red = 4'hF; orange = 4'h0; green = 4'h0;
    #1;
    check_all(-2, PH_IDLE, 2'd0, 4'b0000, 16'd0, 4);
    #1 rst = 1'b1;

    for (int i = split1; i < split2; i++) run_row(i);

    // Two-cycle latency from lamp input to phase output.
    red = 4'b1110; orange = 4'b0001; green = 4'h0;
    @(posedge clk); #1;
    check("lag_edge1_phase", -3, 32'(phase), 32'(PH_IDLE));
    @(posedge clk); #1;
    check("lag_edge2_phase", -3, 32'(phase), 32'(PH_ORANGE));
    check("lag_edge2_dir", -3, 32'(active_dir), 32'd0);

    for (int i = split2; i < vq.size(); i++) run_row(i);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
